// File: rtl/mem_access.sv
// mem_access: byte-serial load/store unit between ex_mem and mem_wb
module mem_access #(
    parameter logic [3:0] OP_NONE = 4'd0,
    parameter logic [3:0] OP_LB   = 4'd1,
    parameter logic [3:0] OP_LH   = 4'd2,
    parameter logic [3:0] OP_LW   = 4'd3,
    parameter logic [3:0] OP_LBU  = 4'd4,
    parameter logic [3:0] OP_LHU  = 4'd5,
    parameter logic [3:0] OP_SB   = 4'd6,
    parameter logic [3:0] OP_SH   = 4'd7,
    parameter logic [3:0] OP_SW   = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    input  logic        ram_gnt,
    input  logic [7:0]  ram_din,
    output logic        ram_req,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stallreq_mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_LAST, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  idx, cap_idx, last_idx;
    logic [31:0] ld_buf, ld_data;
    logic        cap_pend, is_load, is_store, is_mem, issue, pass, done;
    assign is_load  = ex_memop inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    assign is_store = ex_memop inside {OP_SB, OP_SH, OP_SW};
    assign is_mem   = (ex_memop != OP_NONE) && (is_load || is_store);
    assign last_idx = (ex_memop inside {OP_LB, OP_LBU, OP_SB}) ? 2'd0 :
                      (ex_memop inside {OP_LH, OP_LHU, OP_SH}) ? 2'd1 : 2'd3;
    assign issue    = (state == ACCESS) && ram_gnt;
    assign pass     = (state == IDLE) && !is_mem;
    assign done     = state == DONE;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // byte index and load buffer; a read byte lands one cycle after its granted issue
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 2'd0;
            cap_idx  <= 2'd0;
            cap_pend <= 1'b0;
            ld_buf   <= 32'd0;
        end else begin
            idx      <= (state == IDLE) ? 2'd0 : issue ? idx + 2'd1 : idx;
            cap_pend <= issue && is_load;
            cap_idx  <= idx;
            if (cap_pend) ld_buf[{cap_idx, 3'b000} +: 8] <= ram_din;
        end
    end
    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = is_mem ? ACCESS : IDLE;
            ACCESS:    if (ram_gnt && idx == last_idx) state_nx = is_store ? DONE : WAIT_LAST;
            WAIT_LAST: state_nx = DONE;
            default:   state_nx = IDLE;
        endcase
    end
    // load result extension
    always_comb begin
        ld_data = (ex_memop == OP_LB) ? {{24{ld_buf[7]}}, ld_buf[7:0]} :
                  (ex_memop == OP_LH) ? {{16{ld_buf[15]}}, ld_buf[15:0]} :
                  (ex_memop == OP_LBU) ? {24'd0, ld_buf[7:0]} :
                  (ex_memop == OP_LHU) ? {16'd0, ld_buf[15:0]} : ld_buf;
    end
    // outputs, all forced low while reset is held
    always_comb begin
        ram_req      = !rst && (state == ACCESS);
        ram_a        = ram_req ? ex_mem_addr + {30'd0, idx} : 32'd0;
        ram_wr       = !rst && issue && is_store;
        ram_dout     = (!rst && state == ACCESS && is_store) ? ex_store_data[{idx, 3'b000} +: 8] : 8'd0;
        stallreq_mem = !rst && ((state == IDLE) ? is_mem : !done);
        mem_wd       = (!rst && (pass || done)) ? ex_wd : 5'd0;
        mem_wreg     = !rst && (pass || (done && is_load)) && ex_wreg;
        mem_wdata    = rst ? 32'd0 : (pass || (done && is_store)) ? ex_wdata : done ? ld_data : 32'd0;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a transaction-level model
module tb_mem_access;
    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LW = 4'd3, OP_LBU = 4'd4;
    localparam logic [3:0] OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    logic clk = 1'b0, rst;
    logic [4:0] ex_wd;
    logic ex_wreg;
    logic [31:0] ex_wdata, ex_mem_addr, ex_store_data;
    logic [3:0] ex_memop;
    logic ram_gnt;
    logic [7:0] ram_din;
    logic ram_req, ram_wr, mem_wreg, stallreq_mem;
    logic [31:0] ram_a, mem_wdata;
    logic [7:0] ram_dout;
    logic [4:0] mem_wd;

    mem_access dut (
        .clk(clk), .rst(rst), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_memop(ex_memop), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .ram_gnt(ram_gnt), .ram_din(ram_din), .ram_req(ram_req), .ram_a(ram_a),
        .ram_wr(ram_wr), .ram_dout(ram_dout), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    logic [7:0] mem [logic [31:0]];
    bit busy = 0, waited, hold = 0, done_now;
    int issued, n, cyc, done_cyc;
    logic [3:0] t_op;
    logic [31:0] t_addr, t_data, done_data, s_wdata;
    logic done_wreg, s_stall, s_req;
    logic [31:0] alog [$];
    logic [7:0] wlog [$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic bit is_ld(logic [3:0] op);
        return op >= 4'd1 && op <= 4'd5;
    endfunction

    function automatic bit is_st(logic [3:0] op);
        return op >= 4'd6 && op <= 4'd8;
    endfunction

    function automatic int nbytes(logic [3:0] op);
        return (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
               (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
    endfunction

    function automatic logic [7:0] memrd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'(a ^ (a >> 8) ^ 32'h5A);
    endfunction

    function automatic logic [31:0] ldval(logic [3:0] op, logic [31:0] a);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nbytes(op); i++) v[8*i +: 8] = memrd(a + 32'(i));
        if (op == 4'd1) return {{24{v[7]}}, v[7:0]};
        if (op == 4'd2) return {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic step();
        logic er, ew, es, ewr;
        logic [31:0] ea, edata, nra;
        logic [7:0] ed;
        logic [4:0] ewd;
        bit nrd;
        @(negedge clk);
        er = 0; ew = 0; es = 0; ewr = 0; ea = 0; edata = 0; ed = 0; ewd = 0;
        nrd = 0; nra = 0; done_now = 0;
        if (rst) busy = 0;
        else if (!busy) begin
            if (is_ld(ex_memop) || is_st(ex_memop)) begin
                es = 1; busy = 1; issued = 0; waited = 0; cyc = 0;
                t_op = ex_memop; t_addr = ex_mem_addr; t_data = ex_store_data; n = nbytes(ex_memop);
            end else begin
                ewd = ex_wd; ewr = ex_wreg; edata = ex_wdata;
            end
        end else begin
            cyc++;
            if (issued < n) begin
                er = 1; es = 1; ea = t_addr + 32'(issued);
                if (ram_gnt) begin
                    if (is_st(t_op)) begin
                        ew = 1; ed = t_data[8*issued +: 8]; mem[ea] = ed;
                    end else begin
                        nrd = 1; nra = ea;
                    end
                    issued++;
                end
            end else if (is_ld(t_op) && !waited) begin
                es = 1; waited = 1;
            end else begin
                ewd = ex_wd;
                ewr = is_ld(t_op) ? ex_wreg : 1'b0;
                edata = is_ld(t_op) ? ldval(t_op, t_addr) : ex_wdata;
                busy = 0; done_now = 1; done_cyc = cyc; done_data = mem_wdata; done_wreg = mem_wreg;
            end
        end
        chk("ram_req", ram_req, er);
        if (er || rst) chk("ram_a", ram_a, ea);
        chk("ram_wr", ram_wr, ew);
        if (ew || rst) chk("ram_dout", ram_dout, ed);
        chk("stallreq_mem", stallreq_mem, es);
        chk("mem_wd", mem_wd, ewd);
        chk("mem_wreg", mem_wreg, ewr);
        chk("mem_wdata", mem_wdata, edata);
        if (er) alog.push_back(ram_a);
        if (ram_wr) wlog.push_back(ram_dout);
        s_stall = stallreq_mem; s_req = ram_req; s_wdata = mem_wdata;
        hold = es;
        @(posedge clk);
        #1;
        ram_din = nrd ? memrd(nra) : 8'($urandom);
    endtask

    task automatic run_op(logic [3:0] op, logic [31:0] addr, logic [31:0] data, logic [31:0] mask);
        alog.delete(); wlog.delete();
        ex_memop = op; ex_mem_addr = addr; ex_store_data = data;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hC0FFEE00;
        for (int c = 0; c < 40; c++) begin
            ram_gnt = (c < 32) ? mask[c] : 1'b1;
            step();
            if (done_now) break;
        end
        chk("done_seen", 32'(done_now), 32'd1);
    endtask

    initial begin
        rst = 1; ex_memop = OP_NONE; ex_wd = 0; ex_wreg = 0; ex_wdata = 0;
        ex_mem_addr = 0; ex_store_data = 0; ram_gnt = 0; ram_din = 0;
        step(); step();
        chk("rst_stall", 32'(s_stall), 32'd0);
        rst = 0; ex_wd = 5'd5; ex_wreg = 1; ex_wdata = 32'h1234;
        step();
        chk("pass_wdata", s_wdata, 32'h1234);
        chk("pass_stall", 32'(s_stall), 32'd0);
        chk("pass_req", 32'(s_req), 32'd0);
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_op(OP_LW, 32'h100, 32'd0, '1);
        chk("lw_done_cyc", 32'(done_cyc), 32'd6);
        chk("lw_data", done_data, 32'h12345678);
        chk("lw_wreg", 32'(done_wreg), 32'd1);
        chk("lw_alog_n", 32'(alog.size()), 32'd4);
        if (alog.size() == 4)
            for (int i = 0; i < 4; i++) chk("lw_addr", alog[i], 32'h100 + 32'(i));
        mem[32'h20] = 8'h80;
        run_op(OP_LB, 32'h20, 32'd0, '1);
        chk("lb_data", done_data, 32'hFFFFFF80);
        chk("lb_done_cyc", 32'(done_cyc), 32'd3);
        run_op(OP_LBU, 32'h20, 32'd0, '1);
        chk("lbu_data", done_data, 32'h00000080);
        run_op(OP_SH, 32'h3FF, 32'hAABBCCDD, ~32'b100);
        chk("sh_done_cyc", 32'(done_cyc), 32'd4);
        chk("sh_wreg", 32'(done_wreg), 32'd0);
        chk("sh_wlog_n", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("sh_byte0", 32'(wlog[0]), 32'hDD);
            chk("sh_byte1", 32'(wlog[1]), 32'hCC);
        end
        run_op(OP_LW, 32'hFFFFFFFE, 32'd0, '1);
        chk("wrap_alog_n", 32'(alog.size()), 32'd4);
        if (alog.size() == 4) begin
            chk("wrap_a0", alog[0], 32'hFFFFFFFE);
            chk("wrap_a1", alog[1], 32'hFFFFFFFF);
            chk("wrap_a2", alog[2], 32'h0);
            chk("wrap_a3", alog[3], 32'h1);
        end
        run_op(OP_SB, 32'h55, 32'h11, '1);
        chk("sb_done_cyc", 32'(done_cyc), 32'd2);
        run_op(OP_SW, 32'h60, 32'h01020304, '1);
        chk("sw_done_cyc", 32'(done_cyc), 32'd5);
        wlog.delete();
        ex_memop = OP_SW; ex_mem_addr = 32'h200; ex_store_data = 32'hDEADBEEF; ram_gnt = 1;
        step(); step();
        rst = 1;
        step();
        rst = 0; ex_memop = OP_NONE;
        step();
        chk("rst_mid_stall", 32'(s_stall), 32'd0);
        chk("rst_mid_req", 32'(s_req), 32'd0);
        chk("rst_mid_writes", 32'(wlog.size()), 32'd1);
        for (int k = 0; k < 4000; k++) begin
            if (!hold) begin
                int r;
                r = $urandom_range(0, 9);
                ex_memop = (r < 7) ? 4'($urandom_range(1, 8)) : (r == 7) ? OP_NONE : 4'($urandom_range(9, 15));
                ex_mem_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
                ex_store_data = $urandom; ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
            end
            ram_gnt = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 149) == 0;
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
